// File: rtl/instr_decode_queue.sv
// DEPTH-entry instruction FIFO with valid/ready on both sides; the head word is decoded into control fields.
// Optional macro IR_RETIRE_CNT_EN adds a 16-bit retire_count output that counts pops.
module instr_decode_queue #(
  parameter int INSTR_W   = 8,
  parameter int REG_SEL_W = 2,
  parameter int DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [INSTR_W-1:0]        in_instr,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_W-1:0]        instr_out,
  output logic [2:0]                opcode,
  output logic [1:0]                jump_opcode_check,
  output logic                      funct,
  output logic [REG_SEL_W-1:0]      rs,
  output logic [REG_SEL_W-1:0]      rt,
  output logic [REG_SEL_W-1:0]      i_immediate,
  output logic [INSTR_W-4:0]        j_immediate,
  output logic [$clog2(DEPTH):0]    count
`ifdef IR_RETIRE_CNT_EN
  ,
  output logic [15:0]               retire_count
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  // Ready depends only on occupancy, never on out_ready, so no comb path crosses the queue.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_instr;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef IR_RETIRE_CNT_EN
  logic [15:0] retire_q, retire_d;

  // Flush discards the pop, so a flushed cycle retires nothing; only reset clears the total.
  always_comb begin
    retire_d = retire_q;
    if (pop && !flush) retire_d = retire_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`endif

  assign count     = count_q;
  assign instr_out = out_valid ? mem_q[rd_ptr_q] : '0;

  assign opcode            = instr_out[INSTR_W-1:INSTR_W-3];
  assign jump_opcode_check = instr_out[INSTR_W-1:INSTR_W-2];
  assign funct             = instr_out[INSTR_W-4];
  assign rs                = instr_out[2*REG_SEL_W-1:REG_SEL_W];
  assign rt                = instr_out[REG_SEL_W-1:0];
  assign i_immediate       = instr_out[2*REG_SEL_W-1:REG_SEL_W];
  assign j_immediate       = instr_out[INSTR_W-4:0];
endmodule

// File: tb/tb_instr_decode_queue.sv
// Randomized + directed bench for instr_decode_queue against a queue-based reference model.
module tb_instr_decode_queue;
  localparam int INSTR_W   = 8;
  localparam int REG_SEL_W = 2;
  localparam int DEPTH     = 2;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset, flush, in_valid, out_ready;
  logic [INSTR_W-1:0]   in_instr;
  logic                 in_ready, out_valid, funct;
  logic [INSTR_W-1:0]   instr_out;
  logic [2:0]           opcode;
  logic [1:0]           jump_opcode_check;
  logic [REG_SEL_W-1:0] rs, rt, i_immediate;
  logic [INSTR_W-4:0]   j_immediate;
  logic [CNT_W-1:0]     count;
`ifdef IR_RETIRE_CNT_EN
  logic [15:0]          retire_count;
`endif

  instr_decode_queue #(.INSTR_W(INSTR_W), .REG_SEL_W(REG_SEL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .opcode(opcode), .jump_opcode_check(jump_opcode_check), .funct(funct),
    .rs(rs), .rt(rt), .i_immediate(i_immediate), .j_immediate(j_immediate),
    .count(count)
`ifdef IR_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [INSTR_W-1:0] mq [$];
  int unsigned        m_retire = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs derived from the model queue contents and the field definitions.
  task automatic check_all();
    int h, msk;
    h   = (mq.size() != 0) ? int'(mq[0]) : 0;
    msk = (1 << REG_SEL_W) - 1;
    chk("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("count",     32'(count),     32'(mq.size()));
    chk("instr_out", 32'(instr_out), 32'(h));
    chk("opcode",    32'(opcode),    32'((h >> (INSTR_W-3)) & 7));
    chk("jmp_chk",   32'(jump_opcode_check), 32'((h >> (INSTR_W-2)) & 3));
    chk("funct",     32'(funct),     32'((h >> (INSTR_W-4)) & 1));
    chk("rs",        32'(rs),        32'((h >> REG_SEL_W) & msk));
    chk("rt",        32'(rt),        32'(h & msk));
    chk("i_imm",     32'(i_immediate), 32'((h >> REG_SEL_W) & msk));
    chk("j_imm",     32'(j_immediate), 32'(h & ((1 << (INSTR_W-3)) - 1)));
`ifdef IR_RETIRE_CNT_EN
    chk("retire",    32'(retire_count), 32'(m_retire & 16'hFFFF));
`endif
  endtask

  // Drive one cycle, check the pre-edge state, then advance the model on the edge.
  task automatic tick(input logic rst, input logic fl, input logic iv,
                      input logic [INSTR_W-1:0] w, input logic ordy);
    bit do_pop, do_push;
    reset = rst; flush = fl; in_valid = iv; in_instr = w; out_ready = ordy;
    #2;
    check_all();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_retire = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      do_push = iv && (mq.size() < DEPTH);
      do_pop  = ordy && (mq.size() > 0);
      if (do_pop) begin
        void'(mq.pop_front());
        m_retire = (m_retire + 1) & 16'hFFFF;
      end
      if (do_push) mq.push_back(w);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    @(posedge clk); @(posedge clk); #1;
    mq.delete(); m_retire = 0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    // Single push and decode
    tick(1'b0, 1'b0, 1'b1, 8'b10110110, 1'b0);
    chk("d_valid", 32'(out_valid), 32'd1);
    chk("d_count", 32'(count), 32'd1);
    chk("d_opcode", 32'(opcode), 32'b101);
    chk("d_jmp", 32'(jump_opcode_check), 32'b10);
    chk("d_funct", 32'(funct), 32'd1);
    chk("d_rs", 32'(rs), 32'b01);
    chk("d_rt", 32'(rt), 32'b10);
    chk("d_iimm", 32'(i_immediate), 32'b01);
    chk("d_jimm", 32'(j_immediate), 32'b10110);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Fill, then a refused push while full
    tick(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd2);
    tick(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);  // full: 0x11 pops, 0x33 refused
    chk("drain_1", 32'(instr_out), 32'h22);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_zero", 32'(instr_out), 32'd0);

    // Streaming with wrap-around
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
      chk("stream_word", 32'(instr_out), 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Flush beats a simultaneous push
    tick(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    idle(2);

`ifdef IR_RETIRE_CNT_EN
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 8'(i + 8'h40), 1'b1);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("ret_five", 32'(retire_count), 32'd5);
    tick(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    tick(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("ret_flush", 32'(retire_count), 32'd5);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("ret_reset", 32'(retire_count), 32'd0);
`endif

    // Random traffic including mid-operation reset/flush
    for (int n = 0; n < 600; n++) begin
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 6), INSTR_W'($urandom), ($urandom_range(0, 9) < 5));
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
